// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes driven on alu_ctrl and the multiply
// sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response bundle between a multiply requester (master) and the
// shift-add multiply sequencer (slave).
interface alu_mul_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;

  modport master (
    output start, op_a, op_b,
    input  busy, done, product
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, product
  );
endinterface

// File: rtl/alu.sv
// Shared combinational ALU. Carry and overflow are not produced because the
// only client here works modulo 2^WIDTH.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] result
);

  // Select the operation requested on ctrl
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_PASS_B:   result = b;
      ALU_ADD:      result = a + b;
      ALU_SUBTRACT: result = a - b;
      ALU_AND:      result = a & b;
      ALU_OR:       result = a | b;
      ALU_XOR:      result = a ^ b;
      default:      result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier that borrows the shared ALU for its accumulate step.
// Produces the low WIDTH bits of op_a*op_b, one multiplier bit per cycle,
// exiting early once no set multiplier bits remain.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_mul_seq_if.slave     bus,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0] acc_step;

  // Next-state and datapath update for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    // Accumulator value written this RUN cycle (ALU sum only when bit set)
    acc_step  = mplier_q[0] ? alu_result : acc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op_b != '0) begin
            acc_d    = '0;
            mcand_d  = bus.op_a;
            mplier_d = bus.op_b;
            cnt_d    = '0;
            state_d  = RUN;
          end else begin
            // Zero multiplier: skip the loop entirely
            product_d = '0;
            state_d   = DONE;
          end
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if ((mplier_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1))) begin
          product_d = acc_step;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // ALU drive: accumulate only while running, otherwise a harmless PASS_B of 0
  always_comb begin
    alu_ctrl = ALU_PASS_B;
    alu_A    = '0;
    alu_B    = '0;
    if (state_q == RUN) begin
      alu_ctrl = ALU_ADD;
      alu_A    = acc_q;
      alu_B    = mcand_q;
    end
  end

  // Status is a pure decode of the registered state, so start never reaches busy
  assign bus.busy    = (state_q == RUN) || (state_q == DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq paired with the shared ALU.
module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;

  int checks = 0;
  int errors = 0;

  alu_mul_seq_if #(.WIDTH(WIDTH)) mif ();

  alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (mif.slave),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_A),
    .b      (alu_B),
    .ctrl   (alu_ctrl),
    .result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle right after the start edge (cycle 1); returns the
  // cycle number in which done is seen and how many cycles drove ALU_ADD.
  task automatic wait_done(input int limit, output int lat, output int adds);
    lat  = 1;
    adds = 0;
    while (mif.done !== 1'b1 && lat < limit) begin
      chk("busy_in_run", mif.busy, 1);
      if (alu_ctrl == ALU_ADD) adds++;
      tick();
      lat++;
    end
  endtask

  // Launch one multiply from IDLE and check latency, status and product.
  task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_p, input int exp_lat);
    int lat, adds;
    mif.start = 1'b1;
    mif.op_a  = a;
    mif.op_b  = b;
    tick();
    mif.start = 1'b0;
    wait_done(100, lat, adds);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_done"}, mif.done, 1);
    chk({tag, "_busy_done"}, mif.busy, 1);
    chk({tag, "_ctrl_done"}, alu_ctrl, ALU_PASS_B);
    chk({tag, "_product"}, mif.product, exp_p);
    chk({tag, "_add_cycles"}, 64'(adds), 64'(exp_lat - 1));
    tick();
    chk({tag, "_done_pulse"}, mif.done, 0);
    chk({tag, "_busy_after"}, mif.busy, 0);
    chk({tag, "_product_hold"}, mif.product, exp_p);
    $display("txn %s: a=%h b=%h product=%h latency=%0d", tag, a, b, mif.product, lat);
  endtask

  initial begin
    int lat, adds;
    mif.start = 1'b0;
    mif.op_a  = '0;
    mif.op_b  = '0;
    reset_n   = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", mif.busy, 0);
    chk("rst_done", mif.done, 0);
    chk("rst_product", mif.product, 0);
    chk("rst_ctrl", alu_ctrl, ALU_PASS_B);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_ctrl", alu_ctrl, ALU_PASS_B);
    chk("idle_alu_b", alu_B, 0);

    // Basic and boundary multiplies
    run_mul("mul3x5", 64'd3, 64'd5, 64'd15, 4);
    run_mul("zero_b", 64'hDEAD, 64'd0, 64'd0, 1);
    run_mul("max_b", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_mul("neg1x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    run_mul("mixed", 64'h0000_0001_2345_6789, 64'h0000_0000_0001_0001,
            64'h0001_2346_8ACE_6789, 18);

    // Handshake: start while running is ignored; start in DONE is ignored,
    // start held into the following IDLE cycle is accepted.
    mif.start = 1'b1;
    mif.op_a  = 64'd3;
    mif.op_b  = 64'd5;
    tick();
    mif.start = 1'b0;
    tick();
    mif.start = 1'b1;
    mif.op_a  = 64'd7;
    mif.op_b  = 64'd9;
    tick();
    mif.start = 1'b0;
    tick();
    chk("hs_done", mif.done, 1);
    chk("hs_product", mif.product, 64'd15);
    mif.start = 1'b1;
    tick();
    chk("hs_idle_after_done", mif.busy, 0);
    chk("hs_product_hold", mif.product, 64'd15);
    tick();
    mif.start = 1'b0;
    $display("txn handshake_3x5: product=%h", 64'd15);
    wait_done(100, lat, adds);
    chk("hs7x9_latency", 64'(lat), 64'd5);
    chk("hs7x9_product", mif.product, 64'd63);
    tick();
    $display("txn handshake_7x9: product=%h latency=%0d", mif.product, lat);

    // Mid-operation asynchronous reset
    mif.start = 1'b1;
    mif.op_a  = 64'h0000_0001_0000_0000;
    mif.op_b  = 64'h0000_0100_0000_0000;
    tick();
    mif.start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("midrst_busy_before", mif.busy, 1);
    chk("midrst_ctrl_before", alu_ctrl, ALU_ADD);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", mif.busy, 0);
    chk("midrst_done", mif.done, 0);
    chk("midrst_ctrl", alu_ctrl, ALU_PASS_B);
    chk("midrst_product", mif.product, 0);
    tick();
    chk("midrst_no_done", mif.done, 0);
    reset_n = 1'b1;
    tick();
    chk("midrst_idle", mif.busy, 0);
    $display("txn midop_reset: busy=%0d done=%0d", mif.busy, mif.done);
    run_mul("restart", 64'h0000_0001_0000_0000, 64'h0000_0100_0000_0000, 64'd0, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle shift-add multiply sequencer that borrows the shared 64-bit ALU.
- It drives the ALU A/B/ctrl inputs and consumes its result to produce the low 64 bits of A*B. This matches the MUL semantics, and the low half is identical for signed and unsigned operands.
- Sits beside the EX-stage ALU. While `busy`, the EX operand mux selects this block's ALU drive and the pipeline stalls.

Parameters:
- WIDTH, 64, operand/product width; must match ALU width.
- CNT_W, 6, iteration counter width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand; captured on an accepted start.
- op_b  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high in RUN and DONE; EX mux select and stall.
- done  output  1  one-cycle pulse; product valid.
- product  output  WIDTH  result; held until the next accepted start.
- alu_A  output  WIDTH  ALU A operand (accumulator).
- alu_B  output  WIDTH  ALU B operand (shifted multiplicand).
- alu_ctrl  output  3  ALU op code.
- alu_result  input  WIDTH  ALU result, combinational from ALU; must settle within one cycle.

Behaviour:
- Registers: acc[WIDTH], mcand[WIDTH], mplier[WIDTH], cnt[CNT_W], product, state.
- Reset (async, reset_n=0): state=IDLE; acc, mcand, mplier, cnt, product = 0; done=0; busy=0. Applies mid-operation too; the partial result is discarded.
- IDLE:
  - alu_ctrl=PASS_B (000), alu_A=0, alu_B=0.
  - On start with op_b!=0: acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0, go RUN.
  - On start with op_b==0: product<=0, go DONE.
  - With no start, stay.
- RUN (one multiplier bit per cycle):
  - alu_ctrl=ADD (010), alu_A=acc, alu_B=mcand.
  - If mplier[0]=1, acc<=alu_result; else acc holds.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - Early exit: if mplier[WIDTH-1:1]==0 or cnt==WIDTH-1, product <= the acc being written this cycle, go DONE.
- DONE: done=1 for exactly one cycle; alu_ctrl=PASS_B, operands 0; go IDLE.
- Latency: done is high in cycle N+1 after the start edge, where N = index of the highest set bit of op_b + 1 (1..WIDTH). For op_b==0, done is high in the cycle right after start.
- Arithmetic:
  - Modulo 2^WIDTH; ALU carry_out and overflow are ignored.
  - Bits of mcand shifted beyond WIDTH are dropped.
- start while busy: ignored, not queued; the requester must re-assert start after done.
- start and done coincident: impossible, since DONE is followed by IDLE. A start in the DONE cycle is ignored; start is accepted from the following IDLE cycle onward.
- product is registered and stable from the done cycle until the next accepted start.
- busy is a registered-state decode (RUN or DONE); no combinational path from start to busy.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants: ALU_PASS_B=3'b000, ALU_ADD=3'b010, ALU_SUBTRACT=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110.
  - State enum mul_state_t {IDLE, RUN, DONE}.
- No sub-module. The ALU stays external (shared); the bench instantiates alu_mul_seq together with alu.

Test Plan:
- Reset: reset_n=0, then 1. Expect busy=0, done=0, product=0, alu_ctrl=000.
- Small multiply: op_a=3, op_b=5, start for 1 cycle. Expect busy for 4 cycles, done in cycle 4 after the start edge, product=15, alu_ctrl=010 only in the 3 RUN cycles.
- Zero and max multiplier:
  - op_b=0, op_a=64'hDEAD: done the next cycle, product=0.
  - op_a=1, op_b=64'hFFFFFFFFFFFFFFFF: done in cycle 65, product=64'hFFFFFFFFFFFFFFFF.
- Wrap and sign: op_a=64'hFFFFFFFFFFFFFFFF (-1), op_b=2. Expect product=64'hFFFFFFFFFFFFFFFE, latency 2 RUN cycles, no overflow stall.
- Handshake: start re-asserted with op_a=7, op_b=9 while running 3*5. Expect it ignored, product=15. A start with 7*9 in the cycle after done yields product=63.
- Mid-op reset: start op_a=2^32, op_b=2^40 (expected wrap product=0 after 41 RUN cycles). Drop reset_n at RUN cycle 10 (asynchronously, mid-cycle). Expect an immediate return to IDLE, busy=0, no done pulse. A restart then completes with product=0 in cycle 42.
